// File: rtl/acc4_writeback_if.sv
// Bus bundle between the controller/accessor side and acc4_writeback.
// Holds the start/config inputs, the BRAM0 read stream, the state flags and
// the BRAM1 write port.
//   master : the controller/accessor side; drives the *_i signals, observes the *_o signals
//   slave  : acc4_writeback; consumes the *_i signals, drives the *_o signals
interface acc4_writeback_if #(
  parameter int unsigned CNT_BIT  = 31,
  parameter int unsigned DWIDTH_1 = 32,
  parameter int unsigned DWIDTH_2 = 64,
  parameter int unsigned AWIDTH   = 8
);
  logic                start_i;
  logic [CNT_BIT-1:0]  run_count_i;
  logic [AWIDTH-1:0]   res_addr_i;
  logic                rd_en_i;
  logic [DWIDTH_1-1:0] q_b0_i;
  logic                idle_o;
  logic                acc_o;
  logic                write_o;
  logic                done_o;
  logic                ovf_o;
  logic [AWIDTH-1:0]   addr_b1_o;
  logic                ce_b1_o;
  logic                we_b1_o;
  logic [DWIDTH_2-1:0] d_b1_o;

  modport master (
    output start_i, run_count_i, res_addr_i, rd_en_i, q_b0_i,
    input  idle_o, acc_o, write_o, done_o, ovf_o,
    input  addr_b1_o, ce_b1_o, we_b1_o, d_b1_o
  );

  modport slave (
    input  start_i, run_count_i, res_addr_i, rd_en_i, q_b0_i,
    output idle_o, acc_o, write_o, done_o, ovf_o,
    output addr_b1_o, ce_b1_o, we_b1_o, d_b1_o
  );
endinterface

// File: rtl/acc4_writeback.sv
// acc4_writeback: accumulates the four unsigned 8-bit lanes of each BRAM0
// word into 16-bit saturating sums and writes the packed result
// {acc3, acc2, acc1, acc0} into one BRAM1 row, followed by a done pulse.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset
//   bus   : acc4_writeback_if.slave
//           in : start_i, run_count_i, res_addr_i, rd_en_i, q_b0_i
//           out: idle_o/acc_o/write_o/done_o (one-hot state), ovf_o,
//                addr_b1_o, ce_b1_o, we_b1_o, d_b1_o
module acc4_writeback #(
  parameter int unsigned CNT_BIT       = 31,
  parameter int unsigned DWIDTH_1      = 32,
  parameter int unsigned DWIDTH_2      = 64,
  parameter int unsigned AWIDTH        = 8,
  parameter int unsigned IN_DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH     = 16
) (
  input logic             clk,
  input logic             reset,
  acc4_writeback_if.slave bus
);

  localparam int unsigned LANES = DWIDTH_1 / IN_DATA_WIDTH;
  localparam int unsigned SUM_W = ACC_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic                 vld_q;
  logic [CNT_BIT-1:0]   cnt_val_q;
  logic [CNT_BIT-1:0]   sample_cnt_q;
  logic [AWIDTH-1:0]    addr_q;
  logic                 ovf_q;
  logic [ACC_WIDTH-1:0] acc_q [LANES];

  logic                 start_take;
  logic                 acc_take;
  logic [ACC_WIDTH-1:0] acc_d [LANES];
  logic [SUM_W-1:0]     sum_w [LANES];
  logic                 clip_any;
  logic [DWIDTH_1-1:0]  q_w;
  logic [DWIDTH_2-1:0]  d_pack;

  // Per-lane saturating add; the carry bit of the widened sum marks a clip.
  always_comb begin
    q_w      = bus.q_b0_i;
    clip_any = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      sum_w[k] = {1'b0, acc_q[k]} + SUM_W'(q_w[k*IN_DATA_WIDTH +: IN_DATA_WIDTH]);
      acc_d[k] = sum_w[k][ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : sum_w[k][ACC_WIDTH-1:0];
      clip_any = clip_any | sum_w[k][ACC_WIDTH];
    end
  end

  // Next-state logic; valids are only taken in ACC and start only in IDLE.
  always_comb begin
    state_d    = state_q;
    start_take = 1'b0;
    acc_take   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          start_take = 1'b1;
          state_d    = (bus.run_count_i == '0) ? ST_WRITE : ST_ACC;
        end
      end
      ST_ACC: begin
        if (vld_q) begin
          acc_take = 1'b1;
          if ((sample_cnt_q + CNT_BIT'(1)) == cnt_val_q) begin
            state_d = ST_WRITE;
          end
        end
      end
      ST_WRITE: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath: vld models the one-cycle BRAM0 read latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q        <= 1'b0;
      cnt_val_q    <= '0;
      sample_cnt_q <= '0;
      addr_q       <= '0;
      ovf_q        <= 1'b0;
      for (int k = 0; k < LANES; k++) begin
        acc_q[k] <= '0;
      end
    end else begin
      vld_q <= bus.rd_en_i;
      if (start_take) begin
        cnt_val_q    <= bus.run_count_i;
        addr_q       <= bus.res_addr_i;
        sample_cnt_q <= '0;
        ovf_q        <= 1'b0;
        for (int k = 0; k < LANES; k++) begin
          acc_q[k] <= '0;
        end
      end else if (acc_take) begin
        sample_cnt_q <= sample_cnt_q + CNT_BIT'(1);
        ovf_q        <= ovf_q | clip_any;
        for (int k = 0; k < LANES; k++) begin
          acc_q[k] <= acc_d[k];
        end
      end
    end
  end

  // Write data is the live accumulator set, so it also serves as readback after DONE.
  always_comb begin
    d_pack = '0;
    for (int k = 0; k < LANES; k++) begin
      d_pack[k*ACC_WIDTH +: ACC_WIDTH] = acc_q[k];
    end
  end

  assign bus.idle_o    = (state_q == ST_IDLE);
  assign bus.acc_o     = (state_q == ST_ACC);
  assign bus.write_o   = (state_q == ST_WRITE);
  assign bus.done_o    = (state_q == ST_DONE);
  assign bus.ce_b1_o   = (state_q == ST_WRITE);
  assign bus.we_b1_o   = (state_q == ST_WRITE);
  assign bus.ovf_o     = ovf_q;
  assign bus.addr_b1_o = addr_q;
  assign bus.d_b1_o    = d_pack;

endmodule

// File: tb/tb_acc4_writeback.sv
// Directed self-checking bench for acc4_writeback.
module tb_acc4_writeback;

  logic clk = 1'b0;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   wr_cnt   = 0;
  int   done_cnt = 0;
  int   wr0;
  int   dn0;

  acc4_writeback_if bus ();

  acc4_writeback dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Counts BRAM1 writes and done pulses.
  always @(posedge clk) begin
    if (bus.ce_b1_o && bus.we_b1_o) wr_cnt <= wr_cnt + 1;
    if (bus.done_o) done_cnt <= done_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One run with n > 0. pat/plen give the rd_en pattern (plen == 0: n back-to-back).
  // disturb pulses start_i with different config during ACC.
  task automatic run_case(input string tag, input int n, input logic [31:0] word,
                          input logic [7:0] addr, input logic [15:0] pat, input int plen,
                          input bit disturb, input logic [63:0] exp_d, input logic exp_ovf);
    int ncyc;
    int w0;
    int d0;
    w0 = wr_cnt;
    d0 = done_cnt;
    bus.q_b0_i      = word;
    bus.run_count_i = 31'(n);
    bus.res_addr_i  = addr;
    bus.rd_en_i     = 1'b0;
    bus.start_i     = 1'b1;
    tick();
    bus.start_i = 1'b0;
    check({tag, "_acc_at_T1"}, 64'(bus.acc_o), 64'd1);
    ncyc = (plen == 0) ? n : plen;
    for (int i = 0; i < ncyc; i++) begin
      bus.rd_en_i = (plen == 0) ? 1'b1 : pat[i];
      bus.start_i = disturb && (i == 1);
      if (disturb && (i == 1)) begin
        bus.run_count_i = 31'd1;
        bus.res_addr_i  = 8'h77;
      end
      tick();
    end
    bus.start_i = 1'b0;
    bus.rd_en_i = 1'b0;
    check({tag, "_acc_at_last_vld"}, {62'd0, bus.acc_o, bus.write_o}, 64'b10);
    tick();
    check({tag, "_write_flags"}, {61'd0, bus.write_o, bus.ce_b1_o, bus.we_b1_o}, 64'b111);
    check({tag, "_write_addr"}, 64'(bus.addr_b1_o), 64'(addr));
    check({tag, "_write_data"}, bus.d_b1_o, exp_d);
    check({tag, "_no_done_in_write"}, 64'(bus.done_o), 64'd0);
    tick();
    check({tag, "_done"}, {61'd0, bus.done_o, bus.ce_b1_o, bus.we_b1_o}, 64'b100);
    tick();
    check({tag, "_idle"}, 64'(bus.idle_o), 64'd1);
    check({tag, "_ovf"}, 64'(bus.ovf_o), 64'(exp_ovf));
    tick();
    tick();
    check({tag, "_readback"}, bus.d_b1_o, exp_d);
    check({tag, "_ovf_hold"}, 64'(bus.ovf_o), 64'(exp_ovf));
    check({tag, "_write_count"}, 64'(wr_cnt - w0), 64'd1);
    check({tag, "_done_count"}, 64'(done_cnt - d0), 64'd1);
  endtask

  initial begin
    reset           = 1'b1;
    bus.start_i     = 1'b0;
    bus.run_count_i = '0;
    bus.res_addr_i  = '0;
    bus.rd_en_i     = 1'b0;
    bus.q_b0_i      = '0;
    tick();
    tick();

    // Reset state
    check("rst_flags", {59'd0, bus.idle_o, bus.acc_o, bus.write_o, bus.done_o, bus.ovf_o}, 64'b10000);
    check("rst_ce_we", {62'd0, bus.ce_b1_o, bus.we_b1_o}, 64'd0);
    check("rst_addr", 64'(bus.addr_b1_o), 64'd0);
    check("rst_data", bus.d_b1_o, 64'd0);
    reset = 1'b0;
    tick();

    // N=4 back-to-back: done lands at T+7
    run_case("n4", 4, 32'h01020304, 8'h05, 16'h0, 0, 1'b0, 64'h0004_0008_000C_0010, 1'b0);

    // N=300: lane3 saturates
    run_case("n300", 300, 32'hFF000001, 8'h11, 16'h0, 0, 1'b0, 64'hFFFF_0000_0000_012C, 1'b1);

    // N=0: immediate write of zero, rd_en toggling ignored
    wr0 = wr_cnt;
    dn0 = done_cnt;
    bus.q_b0_i      = 32'hFFFFFFFF;
    bus.run_count_i = 31'd0;
    bus.res_addr_i  = 8'h3C;
    bus.start_i     = 1'b1;
    tick();
    bus.start_i = 1'b0;
    check("n0_write_flags", {61'd0, bus.write_o, bus.ce_b1_o, bus.we_b1_o}, 64'b111);
    check("n0_write_addr", 64'(bus.addr_b1_o), 64'h3C);
    check("n0_write_data", bus.d_b1_o, 64'd0);
    bus.rd_en_i = 1'b1;
    tick();
    check("n0_done", 64'(bus.done_o), 64'd1);
    bus.rd_en_i = 1'b0;
    tick();
    check("n0_idle", 64'(bus.idle_o), 64'd1);
    bus.rd_en_i = 1'b1;
    tick();
    bus.rd_en_i = 1'b0;
    tick();
    tick();
    check("n0_no_accum", bus.d_b1_o, 64'd0);
    check("n0_ovf", 64'(bus.ovf_o), 64'd0);
    check("n0_write_count", 64'(wr_cnt - wr0), 64'd1);
    check("n0_done_count", 64'(done_cnt - dn0), 64'd1);

    // rd_en pulsed in IDLE is ignored
    bus.q_b0_i  = 32'h01010101;
    bus.rd_en_i = 1'b1;
    tick();
    bus.rd_en_i = 1'b0;
    tick();
    tick();
    check("idle_vld_ignored", bus.d_b1_o, 64'd0);
    check("idle_vld_state", 64'(bus.idle_o), 64'd1);

    // start_i pulsed during ACC is ignored
    run_case("dist", 4, 32'h01020304, 8'h05, 16'h0, 0, 1'b1, 64'h0004_0008_000C_0010, 1'b0);

    // Reset mid-ACC after lanes have clipped
    wr0 = wr_cnt;
    bus.q_b0_i      = 32'hFFFFFFFF;
    bus.run_count_i = 31'd400;
    bus.res_addr_i  = 8'h22;
    bus.start_i     = 1'b1;
    tick();
    bus.start_i = 1'b0;
    bus.rd_en_i = 1'b1;
    for (int i = 0; i < 260; i++) tick();
    check("pre_rst_ovf", 64'(bus.ovf_o), 64'd1);
    check("pre_rst_acc", 64'(bus.acc_o), 64'd1);
    reset       = 1'b1;
    bus.rd_en_i = 1'b0;
    tick();
    reset = 1'b0;
    check("mid_rst_idle", {59'd0, bus.idle_o, bus.acc_o, bus.write_o, bus.done_o, bus.ovf_o}, 64'b10000);
    check("mid_rst_accs", bus.d_b1_o, 64'd0);
    check("mid_rst_addr", 64'(bus.addr_b1_o), 64'd0);
    tick();
    tick();
    tick();
    check("mid_rst_no_write", 64'(wr_cnt - wr0), 64'd0);

    // Fresh N=2 run after reset
    run_case("n2", 2, 32'h80FF7F01, 8'h09, 16'h0, 0, 1'b0, 64'h0100_01FE_00FE_0002, 1'b0);

    // Gapped valids 1,0,1,1,0,1 for N=4
    run_case("gap", 4, 32'h10101010, 8'hA5, 16'h002D, 6, 1'b0, 64'h0040_0040_0040_0040, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
